// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared widths and FSM state encoding for the main memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int BLK_W  = 29;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module  : mem_array
// Brief   : Single-port word array, synchronous write, combinational read.
// Revision: 1.0 - initial release
// ============================================================================
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    // Contents deliberately have no reset so committed words survive rst_n.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module  : main_memory_responder
// Brief   : Fixed-latency word memory serving cache refill/writeback requests.
// Revision: 1.0 - initial release
// ============================================================================
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [BLK_W-1:0]  req_blk,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int              c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);
    localparam logic [BLK_W-1:0] c_depth    = BLK_W'(DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_write;
    logic [BLK_W-1:0]    r_blk;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_accept;
    logic                w_commit;
    logic                w_oor;
    logic                w_we;
    logic [DATA_W-1:0]   w_rd;

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_commit = (r_state == S_WAIT) && (r_cnt == '0);
    // Full-width compare so high block bits can never alias into the array.
    assign w_oor    = (r_blk >= c_depth);
    assign w_we     = w_commit && r_write && !w_oor;

    mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_addr_w)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_blk[c_addr_w-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_rd)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_commit)  w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_blk       <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt   <= c_cnt_load;
                r_write <= req_write;
                r_blk   <= req_blk;
                r_wdata <= req_wdata;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_rsp_err   <= w_oor;
                r_rsp_rdata <= w_oor ? '0 : (r_write ? r_wdata : w_rd);
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_main_memory_responder
// Brief   : Self-checking bench for main_memory_responder (DEPTH=256, LATENCY=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_main_memory_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [28:0] req_blk;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_vec;
    int n_err;

    logic [32:0] exp_q [$];

    typedef struct {
        logic        wr;
        logic [28:0] blk;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          hold;
    } vec_t;

    vec_t vecs [$];

    main_memory_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_blk   (req_blk),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drives one request, checks latency, optional backpressure, then the scoreboard entry.
    task automatic send(input logic wr, input logic [28:0] blk, input logic [31:0] wd,
                        input int hold, input bit inject);
        int          cyc;
        logic [32:0] exp;
        logic [31:0] held;
        @(negedge clk);
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_blk   = blk;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_blk   = 29'($urandom);
        req_wdata = $urandom;
        cyc = 0;
        while (!rsp_valid && cyc < 30) begin
            if (inject && cyc == 1) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_blk   = 29'h20;
                req_wdata = 32'hBAD0BAD0;
            end
            if (inject && cyc == 3) req_valid = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        req_valid = 1'b0;
        chk("latency", 32'(cyc), 32'(LATENCY));
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got response with empty queue at %0t", $time);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        held = rsp_rdata;
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, held);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        chk("rsp_rdata", rsp_rdata, exp[31:0]);
        chk("rsp_err", 32'(rsp_err), 32'(exp[32]));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("idle_after_hs", 32'({req_ready, rsp_valid, busy}), 32'b100);
    endtask

    task automatic sb_send(input logic wr, input logic [28:0] blk, input logic [31:0] wd,
                           input logic [31:0] erd, input logic eerr, input int hold, input bit inject);
        exp_q.push_back({eerr, erd});
        send(wr, blk, wd, hold, inject);
    endtask

    initial begin
        int cyc;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_blk   = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'({req_ready, rsp_valid, busy, rsp_err}), 32'b1000);
        chk("reset_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //                 wr    blk             wdata          exp_rd         err   hold
        vecs.push_back('{1'b1, 29'h0CE,       32'h01010101, 32'h01010101, 1'b0, 0});
        vecs.push_back('{1'b0, 29'h0CE,       32'h0,        32'h01010101, 1'b0, 0});
        vecs.push_back('{1'b1, 29'h0D1,       32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 0});
        vecs.push_back('{1'b0, 29'h0D1,       32'h0,        32'hAAAAAAAA, 1'b0, 0});
        vecs.push_back('{1'b1, 29'h000,       32'h12345678, 32'h12345678, 1'b0, 0});
        vecs.push_back('{1'b0, 29'h100,       32'h0,        32'h0,        1'b1, 0});
        vecs.push_back('{1'b1, 29'h100,       32'hDEADBEEF, 32'h0,        1'b1, 0});
        vecs.push_back('{1'b0, 29'h000,       32'h0,        32'h12345678, 1'b0, 0});
        vecs.push_back('{1'b1, 29'h0FF,       32'hFFFF0000, 32'hFFFF0000, 1'b0, 0});
        vecs.push_back('{1'b0, 29'h0FF,       32'h0,        32'hFFFF0000, 1'b0, 0});
        vecs.push_back('{1'b1, 29'h100000CE,  32'h77777777, 32'h0,        1'b1, 0});
        vecs.push_back('{1'b0, 29'h0CE,       32'h0,        32'h01010101, 1'b0, 0});
        vecs.push_back('{1'b1, 29'h010,       32'h0BADF00D, 32'h0BADF00D, 1'b0, 0});
        vecs.push_back('{1'b1, 29'h020,       32'h20202020, 32'h20202020, 1'b0, 0});
        vecs.push_back('{1'b0, 29'h0D1,       32'h0,        32'hAAAAAAAA, 1'b0, 3});

        for (int i = 0; i < vecs.size(); i++) begin
            sb_send(vecs[i].wr, vecs[i].blk, vecs[i].wdata,
                    vecs[i].exp_rd, vecs[i].exp_err, vecs[i].hold, 1'b0);
        end

        // Reset two cycles into WAIT aborts the write.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_blk   = 29'h10;
        req_wdata = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_ctrl", 32'({req_ready, rsp_valid, busy, rsp_err}), 32'b1000);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_reset_hold", 32'({req_ready, rsp_valid, busy}), 32'b100);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) cyc++;
        end
        chk("no_rsp_after_abort", 32'(cyc), 32'd0);
        sb_send(1'b0, 29'h010, 32'h0, 32'h0BADF00D, 1'b0, 0, 1'b0);

        // Request pulsed during WAIT must be ignored.
        sb_send(1'b1, 29'h040, 32'h44444444, 32'h44444444, 1'b0, 0, 1'b1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("no_extra_rsp", 32'(rsp_valid), 32'd0);
        sb_send(1'b0, 29'h020, 32'h0, 32'h20202020, 1'b0, 0, 1'b0);
        sb_send(1'b0, 29'h040, 32'h0, 32'h44444444, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words held (block index range 0..DEPTH-1).
REQ-002 Parameter LATENCY, default 4, cycles from request accept to response valid; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  requester (cache miss/writeback path) presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = writeback of req_wdata, 0 = refill read.
REQ-008 req_blk  input  29  block address (cache tag+index, byte address bits [31:3]).
REQ-009 req_wdata  input  32  write data, meaningful only when req_write=1.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  requester consumes the response.
REQ-012 rsp_rdata  output  32  read data (read) or echo of written data (write).
REQ-013 rsp_err  output  1  request addressed outside 0..DEPTH-1.
REQ-014 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 Accept = req_valid & req_ready; on accept, capture req_write/req_blk/req_wdata, load latency counter with LATENCY-1, go to WAIT.
REQ-017 WAIT: counter decrements each cycle; at count 0, perform the access and go to RESP next edge.
REQ-018 rsp_valid rises exactly LATENCY cycles after the accept edge (LATENCY=1: one cycle after accept).
REQ-019 Read: rsp_rdata = stored word at req_blk; rsp_err = 0.
REQ-020 Write: word at req_blk updated exactly once, on the WAIT-to-RESP edge; rsp_rdata = req_wdata; rsp_err = 0.
REQ-021 Out of range (req_blk >= DEPTH): no array write, rsp_rdata = 0, rsp_err = 1, same latency.
REQ-022 RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_valid & rsp_ready; then IDLE next edge.
REQ-023 No same-cycle response/accept overlap; earliest next accept is the cycle after returning to IDLE.
REQ-024 req_valid while not IDLE is ignored (no capture, no side effects); inputs need not be held after accept.
REQ-025 rsp_ready outside RESP has no effect.
REQ-026 Index width = clog2(DEPTH); range check compares the full 29-bit req_blk.
REQ-027 Read-after-write to same block returns the new data once the write response has been issued.

Reset
REQ-028 rst_n low forces IDLE immediately: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, counter=0.
REQ-029 Reset in WAIT before the commit edge aborts the request with no array write; no response is issued.
REQ-030 Array contents are not cleared by reset; previously committed words survive.

Structure
REQ-031 Shared package mem_pkg holds: state enum, BLK_W=29, DATA_W=32, CNT_W=4.
REQ-032 One sub-module mem_array: single-port synchronous word array (DEPTH x 32, write enable, read port), instantiated once.
REQ-033 FSM, counter and range check are in main_memory_responder.

Verification
REQ-034 Read, LATENCY=4: preload word[0xCE]=0x01010101, accept read blk 0xCE at cycle 0 -> rsp_valid at cycle 4, rsp_rdata=0x01010101, rsp_err=0.
REQ-035 Write then read: write blk 0xD1 data 0xAAAAAAAA, then read 0xD1 -> write rsp echoes 0xAAAAAAAA; read returns 0xAAAAAAAA.
REQ-036 Backpressure: rsp_ready low 3 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0 throughout, IDLE one cycle after handshake.
REQ-037 Out of range, DEPTH=256: read/write blk 0x100 -> rsp_err=1, rsp_rdata=0, word[0x00] unchanged.
REQ-038 Reset mid-WAIT: write blk 0x10 data 0x5A5A5A5A, rst_n low at cycle 2 -> no response, word[0x10] keeps old value, req_ready=1 during reset.
REQ-039 Ignored request: req_valid pulsed during WAIT with blk 0x20 -> only the original request is serviced, word[0x20] unchanged.
